alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
// Sequential, parametrised ALU with valid/ready handshakes on operand and result sides.
// Extends the 8-op combinational set with shifts/rotate, full flags (ZF/NF/CF/OF), sticky overflow and an optional iterative multiplier.
// Sits between the operand register file and the writeback stage of the processor datapath.
// PARAMETERS
// WIDTH   32   operand/result width in bits; must be >= 4 and a power of two
// SHW     $clog2(WIDTH)   shift-amount width; derived, not overridden
// PORTS
// CLK        in   1      clock; all logic on rising edge
// RST        in   1      synchronous, active-high reset
// IN_VALID   in   1      operand/opcode presented
// IN_READY   out  1      block accepts operands this cycle
// A          in   WIDTH  operand A
// B          in   WIDTH  operand B; B[SHW-1:0] is the shift amount for shift ops
// OP         in   4      opcode (table below)
// OUT_VALID  out  1      result and flags valid
// OUT_READY  in   1      consumer takes the result
// O          out  WIDTH  result
// OF/CF/ZF/NF out 1 each signed overflow / carry-borrow / zero / negative of O
// ERR        out  1      illegal (or compiled-out) opcode
// BUSY       out  1      multiply in progress
// FLAGS_CLR  in   1      clears STICKY_OF
// STICKY_OF  out  1      OR of OF over all results handed off since reset/clear
// BEHAVIOUR
// - Opcodes: 0 NOT A; 1 AND; 2 XOR; 3 OR; 4 DEC A; 5 ADD; 6 SUB A-B; 7 INC A; 8 SHL; 9 SHR;
//   A SAR; B ROL; C MUL (low WIDTH bits, unsigned); D-F illegal -> O=0, all flags 0, ERR=1.
// - Flags: ZF=(O==0); NF=O[WIDTH-1]. CF: ADD/INC carry-out; SUB borrow (A<B unsigned); DEC borrow (A==0);
//   shifts: last bit shifted out (shift by 0 -> 0); others 0.
//   OF: ADD A,B same sign and O sign differs; SUB A,B sign differ and O sign != A sign;
//   INC A==0111..1; DEC A==1000..0; MUL upper WIDTH product bits nonzero; others 0.
// - FSM states IDLE, MUL, DONE. IN_READY = IDLE | (DONE & OUT_READY).
// - Single-cycle op accepted (IN_VALID & IN_READY) -> DONE next cycle; latency 1.
// - MUL accepted -> MUL state for exactly WIDTH cycles (shift-add, one bit/cycle), BUSY=1 -> DONE.
//   OUT_VALID rises WIDTH+1 cycles after acceptance. A/B captured at acceptance; later input changes ignored.
// - DONE: OUT_VALID=1; O/flags/ERR held stable until OUT_READY. OUT_READY & !IN_VALID -> IDLE.
//   OUT_READY & IN_VALID same cycle -> new op accepted (back-to-back, 1 result/cycle for non-MUL).
// - OUT_READY ignored when OUT_VALID=0; IN_VALID ignored when IN_READY=0.
// - STICKY_OF set on handoff (OUT_VALID & OUT_READY & OF). FLAGS_CLR clears; set wins if both same cycle.
// - Reset (any state, incl. mid-MUL): state IDLE, multiply aborted, O=0, OF=CF=ZF=NF=0, ERR=0,
//   OUT_VALID=0, BUSY=0, STICKY_OF=0; IN_READY=1 first cycle after RST deasserts.
// - Arithmetic wraps modulo 2^WIDTH; all compares on WIDTH bits, no sign-extension beyond WIDTH.
// CONFIGURATION
// ALU_SEQ_MUL_EN defined: OP=C runs the iterative multiplier as above; MUL state and BUSY present.
// Not defined: OP=C treated as illegal (1-cycle, O=0, ERR=1); no MUL state; BUSY tied 0.
// TESTING (WIDTH=32)
// ADD A=0x7FFFFFFF B=1 -> O=0x80000000 OF=1 NF=1 CF=0 ZF=0, OUT_VALID 1 cycle after accept.
// SUB A=0x80000000 B=1 -> O=0x7FFFFFFF OF=1 CF=0; SUB 0-1 -> O=0xFFFFFFFF CF=1 OF=0.
// MUL (EN) A=B=0x00010000 -> O=0 ZF=1 OF=1, OUT_VALID at cycle 33, BUSY=1 cycles 1-32.
// OUT_READY low 5 cycles in DONE -> O/flags stable, IN_READY=0; then 4 back-to-back INC -> 4 results on 4 cycles.
// OP=0xD (and OP=0xC with macro off) -> O=0 ERR=1 flags 0; next legal op clears ERR.
// RST at cycle 10 of a MUL -> all outputs 0 next cycle; STICKY_OF set by OF result, cleared by FLAGS_CLR.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshakes, full flags and sticky overflow
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (OP=C); otherwise OP=C is illegal.
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] O,
  output logic             OF,
  output logic             CF,
  output logic             ZF,
  output logic             NF,
  output logic             ERR,
  output logic             BUSY,
  input  logic             FLAGS_CLR,
  output logic             STICKY_OF
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_NOT = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SAR = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t state_q, state_d;

  logic [WIDTH-1:0] o_q;
  logic             of_q, cf_q, zf_q, nf_q, err_q, sticky_q;
  logic             is_mul;
  logic             accept;

  logic [WIDTH-1:0]   res;
  logic               res_c, res_v, res_e;
  logic [WIDTH:0]     sum_ext;
  logic [2*WIDTH-1:0] rot;
  logic [SHW-1:0]     shamt;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, mcand_q, prod_nxt;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;
  logic               mul_last;

  assign is_mul   = (OP == OP_MUL);
  assign prod_nxt = mplier_q[0] ? prod_q + mcand_q : prod_q;
  assign mul_last = (cnt_q == SHW'(WIDTH - 1));
`else
  assign is_mul = 1'b0;
`endif

  assign shamt  = B[SHW-1:0];
  assign accept = IN_VALID & IN_READY;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b0;
    case (state_q)
      IDLE: IN_READY = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        BUSY = 1'b1;
        if (mul_last) state_d = DONE;
      end
`endif
      DONE: begin
        OUT_VALID = 1'b1;
        IN_READY  = OUT_READY;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new operation overrides the IDLE/DONE transition above.
    if (IN_READY && IN_VALID) begin
`ifdef ALU_SEQ_MUL_EN
      state_d = is_mul ? MUL : DONE;
`else
      state_d = DONE;
`endif
    end
  end

  // Single-cycle result and flags, computed straight from the live operands.
  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_e   = 1'b0;
    sum_ext = '0;
    rot     = '0;
    case (OP)
      OP_NOT: res = ~A;
      OP_AND: res = A & B;
      OP_XOR: res = A ^ B;
      OP_OR:  res = A | B;
      OP_DEC: begin
        res   = A - WIDTH'(1);
        res_c = (A == '0);
        res_v = (A == MIN_NEG);
      end
      OP_ADD: begin
        sum_ext = {1'b0, A} + {1'b0, B};
        res     = sum_ext[WIDTH-1:0];
        res_c   = sum_ext[WIDTH];
        res_v   = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
      end
      OP_SUB: begin
        res   = A - B;
        res_c = (A < B);
        res_v = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
      end
      OP_INC: begin
        sum_ext = {1'b0, A} + (WIDTH+1)'(1);
        res     = sum_ext[WIDTH-1:0];
        res_c   = sum_ext[WIDTH];
        res_v   = (A == MAX_POS);
      end
      // The extra bit beside A catches the last bit shifted out; zero shift leaves it 0.
      OP_SHL: {res_c, res} = {1'b0, A} << shamt;
      OP_SHR: {res, res_c} = {A, 1'b0} >> shamt;
      OP_SAR: {res, res_c} = $signed({A, 1'b0}) >>> shamt;
      OP_ROL: begin
        rot   = {A, A} << shamt;
        res   = rot[2*WIDTH-1:WIDTH];
        res_c = (shamt != '0) & res[0];
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: res = '0;
`endif
      default: res_e = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      o_q      <= '0;
      of_q     <= 1'b0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      if (accept && !is_mul) begin
        o_q   <= res;
        of_q  <= res_v;
        cf_q  <= res_c;
        zf_q  <= (res == '0) & ~res_e;
        nf_q  <= res[MSB];
        err_q <= res_e;
      end
`ifdef ALU_SEQ_MUL_EN
      if (accept && is_mul) begin
        prod_q   <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, A};
        mplier_q <= B;
        cnt_q    <= '0;
      end else if (state_q == MUL) begin
        prod_q   <= prod_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SHW'(1);
        if (mul_last) begin
          o_q   <= prod_nxt[WIDTH-1:0];
          of_q  <= |prod_nxt[2*WIDTH-1:WIDTH];
          cf_q  <= 1'b0;
          zf_q  <= (prod_nxt[WIDTH-1:0] == '0);
          nf_q  <= prod_nxt[WIDTH-1];
          err_q <= 1'b0;
        end
      end
`endif
      // Overflow on a handed-off result takes priority over a clear in the same cycle.
      if (OUT_VALID && OUT_READY && of_q) sticky_q <= 1'b1;
      else if (FLAGS_CLR)                 sticky_q <= 1'b0;
    end
  end

  assign O         = o_q;
  assign OF        = of_q;
  assign CF        = cf_q;
  assign ZF        = zf_q;
  assign NF        = nf_q;
  assign ERR       = err_q;
  assign STICKY_OF = sticky_q;

endmodule
